// File: rtl/cla_pkg.sv
// Shared types for the CLA generate/propagate front-end.
// Optional macro CLA_PG_GROUP_EN adds 4-bit group generate/propagate fields.
package cla_pkg;

  localparam int unsigned CLA_WIDTH  = 8;
  localparam int unsigned CLA_GROUPS = CLA_WIDTH / 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [CLA_WIDTH-1:0]  g;
    logic [CLA_WIDTH-1:0]  p;
    logic                  c0;
`ifdef CLA_PG_GROUP_EN
    logic [CLA_GROUPS-1:0] gg;
    logic [CLA_GROUPS-1:0] gp;
`endif
  } pg_entry_t;

  // Nibble lookahead: returns {group generate, group propagate}.
  function automatic logic [1:0] group_gp(input logic [3:0] g4, input logic [3:0] p4);
    logic ggen;
    logic gprop;
    ggen  = g4[3]
          | (p4[3] & g4[2])
          | (p4[3] & p4[2] & g4[1])
          | (p4[3] & p4[2] & p4[1] & g4[0]);
    gprop = &p4;
    return {ggen, gprop};
  endfunction

endpackage

// File: rtl/cla_pg_skid_buf.sv
// Two-entry FIFO output buffer for g/p/c0 entries.
// in_ready_o depends only on registered state; head entry always drives out_entry_o.
module cla_pg_skid_buf
  import cla_pkg::*;
#(
  parameter type entry_t = pg_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  entry_t in_entry_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t out_entry_o
);

  buf_state_t state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       in_xfer;
  logic       out_xfer;

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_entry_o = head_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_ready_i & out_valid_o;

  // Next-state and entry movement for the EMPTY/ONE/TWO occupancy FSM.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          head_d  = in_entry_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d  = in_entry_i;
        end else if (in_xfer) begin
          tail_d  = in_entry_i;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and entry registers; reset discards everything buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/cla_pg_stage.sv
// Registered generate/propagate front-end of the CLA datapath.
// Optional macro CLA_PG_GROUP_EN adds nibble group outputs gg/gp.
module cla_pg_stage
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               carry_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   g,
  output logic [WIDTH-1:0]   p,
`ifdef CLA_PG_GROUP_EN
  output logic [WIDTH/4-1:0] gg,
  output logic [WIDTH/4-1:0] gp,
`endif
  output logic               c0
);

  if (WIDTH % 4 != 0) begin : g_bad_width
    $error("cla_pg_stage: WIDTH must be a multiple of 4");
  end

  // Local entry type so WIDTH overrides other than CLA_WIDTH still fit.
  typedef struct packed {
    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   p;
    logic               c0;
`ifdef CLA_PG_GROUP_EN
    logic [WIDTH/4-1:0] gg;
    logic [WIDTH/4-1:0] gp;
`endif
  } stage_entry_t;

  stage_entry_t     entry_n;
  stage_entry_t     head;
  logic [WIDTH-1:0] b_eff;

  // Combinational pg front: optional b inversion, per-bit g/p, carry into bit 0.
  always_comb begin
    entry_n    = '0;
    b_eff      = sub ? ~b : b;
    entry_n.g  = a & b_eff;
    entry_n.p  = a ^ b_eff;
    entry_n.c0 = carry_in ^ sub;
`ifdef CLA_PG_GROUP_EN
    for (int unsigned k = 0; k < WIDTH / 4; k++) begin
      {entry_n.gg[k], entry_n.gp[k]} = group_gp(entry_n.g[4*k +: 4], entry_n.p[4*k +: 4]);
    end
`endif
  end

  cla_pg_skid_buf #(
    .entry_t (stage_entry_t)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_entry_i  (entry_n),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_entry_o (head)
  );

  assign g  = head.g;
  assign p  = head.p;
  assign c0 = head.c0;
`ifdef CLA_PG_GROUP_EN
  assign gg = head.gg;
  assign gp = head.gp;
`endif

endmodule

// File: tb/tb_cla_pg_stage.sv
// Self-checking bench for cla_pg_stage with a FIFO scoreboard.
module tb_cla_pg_stage;

  localparam int W = 8;
`ifdef CLA_PG_GROUP_EN
  localparam int EW = 2*W + 1 + 2*(W/4);
`else
  localparam int EW = 2*W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic         c0;
`ifdef CLA_PG_GROUP_EN
  logic [W/4-1:0] gg;
  logic [W/4-1:0] gp;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  cla_pg_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g         (g),
    .p         (p),
`ifdef CLA_PG_GROUP_EN
    .gg        (gg),
    .gp        (gp),
`endif
    .c0        (c0)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [EW-1:0] model_pg(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic mc, input logic ms);
    logic [W-1:0] be, mg, mp;
`ifdef CLA_PG_GROUP_EN
    logic [W/4-1:0] mgg, mgp;
`endif
    be = ms ? ~mb : mb;
    mg = ma & be;
    mp = ma ^ be;
`ifdef CLA_PG_GROUP_EN
    for (int k = 0; k < W/4; k++) begin
      mgg[k] = mg[4*k+3] | (mp[4*k+3] & mg[4*k+2]) | (mp[4*k+3] & mp[4*k+2] & mg[4*k+1])
             | (mp[4*k+3] & mp[4*k+2] & mp[4*k+1] & mg[4*k]);
      mgp[k] = mp[4*k] & mp[4*k+1] & mp[4*k+2] & mp[4*k+3];
    end
    return {mg, mp, mc ^ ms, mgg, mgp};
`else
    return {mg, mp, mc ^ ms};
`endif
  endfunction

  function automatic logic [EW-1:0] observed();
`ifdef CLA_PG_GROUP_EN
    return {g, p, c0, gg, gp};
`else
    return {g, p, c0};
`endif
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dc, input logic ds);
    in_valid = v;
    a        = da;
    b        = db;
    carry_in = dc;
    sub      = ds;
  endtask

  // One clock: compare handshake/head against the model at negedge, then advance past posedge.
  task automatic cycle();
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) begin
        check_eq("head", 64'(observed()), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model_pg(a, b, carry_in, sub));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] sum;
    logic         cr;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_g", {56'd0, g}, 64'd0);
    check_eq("rst_p", {56'd0, p}, 64'd0);
    check_eq("rst_c0", {63'd0, c0}, 64'd0);

    // Add: latency one, known g/p
    out_ready = 1'b1;
    drive(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("add_valid", {63'd0, out_valid}, 64'd1);
    check_eq("add_g", {56'd0, g}, 64'h0C);
    check_eq("add_p", {56'd0, p}, 64'h33);
    check_eq("add_c0", {63'd0, c0}, 64'd0);
`ifdef CLA_PG_GROUP_EN
    check_eq("add_gg", {62'd0, gg}, 64'd1);
    check_eq("add_gp", {62'd0, gp}, 64'd0);
`endif
    cycle();

    // Subtract: a - b with no borrow
    drive(1'b1, 8'h10, 8'h01, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("sub_g", {56'd0, g}, 64'h10);
    check_eq("sub_p", {56'd0, p}, 64'hEE);
    check_eq("sub_c0", {63'd0, c0}, 64'd1);
    cr = c0;
    for (int i = 0; i < W; i++) begin
      sum[i] = p[i] ^ cr;
      cr     = g[i] | (p[i] & cr);
    end
    check_eq("sub_sum", {56'd0, sum}, 64'h0F);
    cycle();
    cycle();

    // Backpressure: third word held until state leaves TWO
    out_ready = 1'b0;
    drive(1'b1, 8'hA1, 8'h5B, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 8'h72, 8'h9C, 1'b0, 1'b1);
    cycle();
    check_eq("bp_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 8'hE4, 8'h33, 1'b1, 1'b1);
    cycle();
    cycle();
    check_eq("bp_hold", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    cycle();
    check_eq("bp_open", {63'd0, in_ready}, 64'd1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("bp_third", 64'(observed()), 64'(model_pg(8'hE4, 8'h33, 1'b1, 1'b1)));
    cycle();
    cycle();

    // Simultaneous in/out transfer while in ONE
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("sim_valid", {63'd0, out_valid}, 64'd1);
    check_eq("sim_ready", {63'd0, in_ready}, 64'd1);
    check_eq("sim_head", 64'(observed()), 64'(model_pg(8'hF0, 8'h0F, 1'b1, 1'b0)));
    cycle();
    cycle();

    // Reset while TWO: everything discarded
    out_ready = 1'b0;
    drive(1'b1, 8'h55, 8'hAA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 8'h66, 8'h99, 1'b1, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("mid_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("mid_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("mid_g", {56'd0, g}, 64'd0);
    check_eq("mid_p", {56'd0, p}, 64'd0);
    check_eq("mid_c0", {63'd0, c0}, 64'd0);
    for (int i = 0; i < 4; i++) cycle();

    // Full throughput with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      cycle();
      check_eq("thru_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            1'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_pg_stage.md
Name: cla_pg_stage

Overview:
Registered generate/propagate front-end of the 8-bit CLA datapath. It sits directly upstream of the carry-lookahead logic.
- Accepts operand pairs over a valid/ready handshake.
- Optionally inverts b for subtraction.
- Forms per-bit g = a & b_eff, p = a ^ b_eff and the carry-in c0.
- Holds results in a 2-entry output buffer so the carry/sum stages see stable, registered g/p/c0.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of 4.

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair present
in_ready  out  1  stage can accept an operand pair this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
carry_in  in  1  carry-in for add; borrow-in for subtract
sub  in  1  1 = compute a - b - borrow
out_valid  out  1  g/p/c0 valid
out_ready  in  1  downstream carry stage accepts
g  out  WIDTH  per-bit generate
p  out  WIDTH  per-bit propagate
c0  out  1  carry into bit 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Combinational front:
  - b_eff = sub ? ~b : b.
  - g_n = a & b_eff; p_n = a ^ b_eff.
  - c0_n = carry_in ^ sub. For sub, c0 = ~borrow.
- Input transfer: occurs on a clk edge with in_valid & in_ready.
- Output transfer: occurs on a clk edge with out_valid & out_ready.
- Buffer FSM states: EMPTY, ONE, TWO.
  - EMPTY: in xfer -> ONE. The entry is written to the head, so out_valid rises the next cycle (latency 1).
  - ONE:
    - in xfer only -> TWO.
    - out xfer only -> EMPTY.
    - Both -> stay in ONE; the head is replaced by the new entry.
  - TWO:
    - out xfer -> ONE; the second entry moves to the head.
    - No input accepted in TWO.
- Handshake signals:
  - in_ready = (state != TWO), driven from registered state only. It has no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - g/p/c0 always reflect the head entry.
- Handshake rules:
  - Ordering is strictly FIFO.
  - g/p/c0 hold stable while out_valid & !out_ready.
  - in_valid may drop without a transfer; nothing is captured without in_ready.
- Reset values:
  - state = EMPTY.
  - out_valid = 0, in_ready = 1.
  - g = 0, p = 0, c0 = 0.
  - Both entries cleared.
- Reset mid-operation: all buffered entries are discarded. No output transfer occurs in the reset cycle. in_ready reads 1 on the first cycle after reset deasserts.
- Full throughput: one transfer per cycle in steady state when out_ready is held high.

Optional Feature:
- Macro: CLA_PG_GROUP_EN.
- When defined:
  - Adds outputs gg and gp, each WIDTH/4 bits: 4-bit group generate/propagate per nibble.
  - gg[k] = g3 | p3g2 | p3p2g1 | p3p2p1g0 over nibble k.
  - gp[k] = &p[4k+3:4k].
  - Computed on input and stored in the buffer alongside g/p, so they follow the same timing and reset-to-0 rules.
- When undefined: ports absent, no group logic.

Decomposition:
- Package cla_pkg:
  - CLA_WIDTH = 8.
  - Typedef pg_entry_t {g, p, c0, plus gg, gp under the macro}.
  - Enum buf_state_t {EMPTY, ONE, TWO}.
- One sub-module, cla_pg_skid_buf: the 2-entry buffer of pg_entry_t, holding the FSM and handshake.
- The top module contains only the combinational pg front plus the instance.

Test Plan:
- Add:
  - Stimulus: a=0x3C, b=0x0F, carry_in=0, sub=0, out_ready=1.
  - Response: one cycle later out_valid=1, g=0x0C, p=0x33, c0=0.
  - With CLA_PG_GROUP_EN: gg=2'b01, gp=2'b00.
- Subtract:
  - Stimulus: a=0x10, b=0x01, sub=1, carry_in=0.
  - Response: g=0x10, p=0xEE, c0=1. Downstream sum equals 0x0F.
- Backpressure:
  - Stimulus: out_ready=0, three consecutive in_valid words.
  - Response: the first two are accepted; in_ready=0 from the cycle after the second transfer; the third is held.
  - Then set out_ready=1. Response: outputs emerge in order, one per cycle, and the third is accepted once state leaves TWO.
- Simultaneous transfer: in state ONE, in xfer and out xfer on the same edge -> state stays ONE and the head becomes the new word.
- Reset mid-stream:
  - Stimulus: rst=1 for one cycle while state=TWO.
  - Response: next cycle out_valid=0, in_ready=1, g=p=0, c0=0; no stale word ever appears afterwards.
- Random throughput:
  - Stimulus: 1000 random a/b/sub/carry_in words with random in_valid/out_ready.
  - Response: a scoreboard confirms in-order, lossless g/p/c0 matching the reference equations.
